pipeline_mem_memwb: RTL and testbench

//  MEM stage plus MEM/WB pipeline register of the 5-stage MIPS core; consumes the 73-bit EX/MEM bundle.

---
 rtl/pipeline_mem_memwb.sv | 207 ++++++++++++++++++++
 tb/tb_pipeline_mem_memwb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem_memwb.sv
// MEM stage + MEM/WB register: data RAM, memory-mapped timer/LED/switch/7-seg, writeback bundle.
// Optional timer (TH/TL/TCON, irqout) is built only when MEM_TIMER_EN is defined.
module pipeline_mem_memwb #(
  parameter int unsigned RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [72:0] exmem,
  input  logic [7:0]  switch,
  output logic [70:0] memwb,
  output logic [31:0] data_exmem,
  output logic [31:0] wb_data,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED  = 32'h4000_000C;
  localparam logic [31:0] ADDR_SW   = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI = 32'h4000_0014;

  logic [4:0]  w_rd;
  logic        w_regwrite;
  logic        w_memread;
  logic        w_memwrite;
  logic        w_memtoreg;
  logic [31:0] w_wdata;
  logic [31:0] w_addr;
  logic [31:0] w_waddr;

  assign w_rd       = exmem[72:68];
  assign w_regwrite = exmem[67];
  assign w_memread  = exmem[66];
  assign w_memwrite = exmem[65];
  assign w_memtoreg = exmem[64];
  assign w_wdata    = exmem[63:32];
  assign w_addr     = exmem[31:0];
  assign w_waddr    = {w_addr[31:2], 2'b00};

  logic w_ram_hit;
  logic w_sel_th;
  logic w_sel_tl;
  logic w_sel_tcon;
  logic w_sel_led;
  logic w_sel_sw;
  logic w_sel_digi;

  assign w_ram_hit  = (w_addr[31:AW+2] == '0);
  assign w_sel_th   = (w_waddr == ADDR_TH);
  assign w_sel_tl   = (w_waddr == ADDR_TL);
  assign w_sel_tcon = (w_waddr == ADDR_TCON);
  assign w_sel_led  = (w_waddr == ADDR_LED);
  assign w_sel_sw   = (w_waddr == ADDR_SW);
  assign w_sel_digi = (w_waddr == ADDR_DIGI);

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] w_ram_q;

  assign w_ram_q = r_ram[w_addr[AW+1:2]];

  // RAM has no reset, so a store that coincides with reset is squashed here.
  always_ff @(posedge clk) begin
    if (!reset && w_memwrite && w_ram_hit) begin
      r_ram[w_addr[AW+1:2]] <= w_wdata;
    end
  end

  logic [31:0] w_th_q;
  logic [31:0] w_tl_q;
  logic [31:0] w_tcon_q;

`ifdef MEM_TIMER_EN
  typedef enum logic {
    T_IDLE  = 1'b0,
    T_COUNT = 1'b1
  } tmr_state_e;

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [31:0] w_th_nxt;
  logic [31:0] w_tl_nxt;
  logic [2:0]  w_tcon_nxt;
  tmr_state_e  w_tstate;

  always_comb begin
    w_tstate = r_tcon[0] ? T_COUNT : T_IDLE;
  end

  // Hardware update first; software writes afterwards so they take priority.
  always_comb begin
    w_th_nxt   = r_th;
    w_tl_nxt   = r_tl;
    w_tcon_nxt = r_tcon;
    case (w_tstate)
      T_COUNT: begin
        if (r_tl == '1) begin
          w_tl_nxt = r_th;
          if (r_tcon[1]) begin
            w_tcon_nxt[2] = 1'b1;
          end
        end else begin
          w_tl_nxt = r_tl + 32'd1;
        end
      end
      default: begin
        w_tl_nxt = r_tl;
      end
    endcase
    if (w_memwrite) begin
      if (w_sel_th) begin
        w_th_nxt = w_wdata;
      end
      if (w_sel_tl) begin
        w_tl_nxt = w_wdata;
      end
      if (w_sel_tcon) begin
        w_tcon_nxt = w_wdata[2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      r_th   <= w_th_nxt;
      r_tl   <= w_tl_nxt;
      r_tcon <= w_tcon_nxt;
    end
  end

  assign w_th_q   = r_th;
  assign w_tl_q   = r_tl;
  assign w_tcon_q = {29'b0, r_tcon};
  assign irqout   = r_tcon[1] & r_tcon[2];
`else
  assign w_th_q   = '0;
  assign w_tl_q   = '0;
  assign w_tcon_q = '0;
  assign irqout   = 1'b0;
`endif

  logic [7:0]  r_led;
  logic [11:0] r_digi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led  <= '0;
      r_digi <= '0;
    end else if (w_memwrite) begin
      if (w_sel_led) begin
        r_led <= w_wdata[7:0];
      end
      if (w_sel_digi) begin
        r_digi <= w_wdata[11:0];
      end
    end
  end

  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_memread) begin
      if (w_ram_hit) begin
        w_rdata = w_ram_q;
      end else if (w_sel_th) begin
        w_rdata = w_th_q;
      end else if (w_sel_tl) begin
        w_rdata = w_tl_q;
      end else if (w_sel_tcon) begin
        w_rdata = w_tcon_q;
      end else if (w_sel_led) begin
        w_rdata = {24'b0, r_led};
      end else if (w_sel_sw) begin
        w_rdata = {24'b0, switch};
      end else if (w_sel_digi) begin
        w_rdata = {20'b0, r_digi};
      end
    end
  end

  logic [70:0] r_memwb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_memwb <= '0;
    end else begin
      r_memwb <= {w_rd, w_regwrite, w_memtoreg, w_rdata, w_addr};
    end
  end

  assign memwb      = r_memwb;
  assign data_exmem = w_addr;
  assign wb_data    = r_memwb[64] ? r_memwb[63:32] : r_memwb[31:0];
  assign led        = r_led;
  assign digi       = r_digi;

endmodule

// File: tb/tb_pipeline_mem_memwb.sv
// Randomized bench for pipeline_mem_memwb against an address-map reference model.
// Timer checks are active when MEM_TIMER_EN is defined; otherwise timer addresses must read 0.
module tb_pipeline_mem_memwb;

  logic        clk = 1'b0;
  logic        reset;
  logic [72:0] exmem;
  logic [7:0]  switch;
  logic [70:0] memwb;
  logic [31:0] data_exmem;
  logic [31:0] wb_data;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  pipeline_mem_memwb #(.RAM_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .exmem      (exmem),
    .switch     (switch),
    .memwb      (memwb),
    .data_exmem (data_exmem),
    .wb_data    (wb_data),
    .led        (led),
    .digi       (digi),
    .irqout     (irqout)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] m_ram [256];
  logic [7:0]  m_led;
  logic [11:0] m_digi;
  logic [31:0] m_th;
  logic [31:0] m_tl;
  logic [2:0]  m_tcon;
  logic [70:0] m_memwb;

  task automatic check_eq(input string tag, input logic [70:0] got, input logic [70:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'd1024) return m_ram[w[9:2]];
    case (w)
      32'h4000_000C: return {24'b0, m_led};
      32'h4000_0010: return {24'b0, switch};
      32'h4000_0014: return {20'b0, m_digi};
`ifdef MEM_TIMER_EN
      32'h4000_0000: return m_th;
      32'h4000_0004: return m_tl;
      32'h4000_0008: return {29'b0, m_tcon};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_irq();
`ifdef MEM_TIMER_EN
    return m_tcon[1] & m_tcon[2];
`else
    return 1'b0;
`endif
  endfunction

  // One pipeline cycle: drive the bundle, predict, clock, compare.
  task automatic step(input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                      input logic m2r, input logic [31:0] wd, input logic [31:0] a);
    logic [31:0] rdat;
    logic [31:0] w;
    logic [31:0] tl_n;
    logic [2:0]  tcon_n;
    exmem = {rd, rw, mr, mw, m2r, wd, a};
    #1;
    check_eq("data_exmem", {39'b0, data_exmem}, {39'b0, a});
    rdat    = mr ? model_read(a) : 32'h0;
    m_memwb = {rd, rw, m2r, rdat, a};
    w       = {a[31:2], 2'b00};
    tl_n    = m_tl;
    tcon_n  = m_tcon;
`ifdef MEM_TIMER_EN
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        tl_n = m_th;
        if (m_tcon[1]) tcon_n[2] = 1'b1;
      end else begin
        tl_n = m_tl + 32'd1;
      end
    end
`endif
    if (mw) begin
      if (w < 32'd1024) m_ram[w[9:2]] = wd;
      else begin
        case (w)
          32'h4000_000C: m_led  = wd[7:0];
          32'h4000_0014: m_digi = wd[11:0];
`ifdef MEM_TIMER_EN
          32'h4000_0000: m_th   = wd;
          32'h4000_0004: tl_n   = wd;
          32'h4000_0008: tcon_n = wd[2:0];
`endif
          default: ;
        endcase
      end
    end
    m_tl   = tl_n;
    m_tcon = tcon_n;
    @(posedge clk);
    #1;
    check_eq("memwb",   memwb, m_memwb);
    check_eq("wb_data", {39'b0, wb_data}, {39'b0, (m2r ? rdat : a)});
    check_eq("led",     {63'b0, led}, {63'b0, m_led});
    check_eq("digi",    {59'b0, digi}, {59'b0, m_digi});
    check_eq("irqout",  {70'b0, irqout}, {70'b0, model_irq()});
  endtask

  task automatic lw(input logic [31:0] a, input logic m2r);
    step(5'd3, 1'b1, 1'b1, 1'b0, m2r, 32'h0, a);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    step(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, d, a);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0, 1:    a = {22'b0, 8'($urandom), 2'($urandom)};
      2:       a = 32'h4000_0000 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      3: begin
        case ($urandom_range(0, 2))
          0:       a = 32'h0000_0800;
          1:       a = 32'h5000_0000;
          default: a = 32'h4000_0018;
        endcase
      end
      4:       a = $urandom;
      default: a = {22'b0, 8'($urandom), 2'b00};
    endcase
    return a;
  endfunction

  initial begin
    reset  = 1'b1;
    exmem  = '0;
    switch = '0;
    m_led  = '0;
    m_digi = '0;
    m_th   = '0;
    m_tl   = '0;
    m_tcon = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_memwb",  memwb, 71'h0);
    check_eq("rst_led",    {63'b0, led}, 71'h0);
    check_eq("rst_digi",   {59'b0, digi}, 71'h0);
    check_eq("rst_irqout", {70'b0, irqout}, 71'h0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) sw(32'(i * 4), $urandom);

    // Store then load
    sw(32'h10, 32'hDEAD_BEEF);
    lw(32'h10, 1'b1);
    check_eq("st_ld_rdata", {39'b0, memwb[63:32]}, {39'b0, 32'hDEAD_BEEF});
    check_eq("st_ld_wb",    {39'b0, wb_data}, {39'b0, 32'hDEAD_BEEF});

    // Out of range
    lw(32'h0000_0800, 1'b1);
    check_eq("oor_rdata", {39'b0, memwb[63:32]}, 71'h0);
    sw(32'h5000_0000, 32'hFFFF_FFFF);

    // Peripherals
    switch = 8'hA5;
    lw(32'h4000_0010, 1'b1);
    check_eq("switch_rd", {39'b0, memwb[63:32]}, {39'b0, 32'h0000_00A5});
    sw(32'h4000_000C, 32'h0000_01FF);
    check_eq("led_ff", {63'b0, led}, {63'b0, 8'hFF});
    sw(32'h4000_0014, 32'hFFFF_F5A3);
    lw(32'h4000_0014, 1'b1);
    check_eq("digi_rd", {39'b0, memwb[63:32]}, {39'b0, 32'h0000_05A3});

    // Read and write together return the old value
    sw(32'h20, 32'h1111_1111);
    step(5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2222_2222, 32'h20);
    check_eq("rw_old", {39'b0, wb_data}, {39'b0, 32'h1111_1111});

`ifdef MEM_TIMER_EN
    sw(32'h4000_0000, 32'hFFFF_FFFE);
    sw(32'h4000_0004, 32'hFFFF_FFFD);
    sw(32'h4000_0008, 32'h0000_0003);
    repeat (4) lw(32'h4000_0004, 1'b1);
    lw(32'h4000_0008, 1'b1);
    check_eq("tcon_wrap", {39'b0, memwb[63:32]}, {39'b0, 32'h0000_0007});
    check_eq("irq_wrap",  {70'b0, irqout}, 71'h1);
    sw(32'h4000_0008, 32'h0000_0001);
    sw(32'h4000_0004, 32'h0000_0100);
    lw(32'h4000_0004, 1'b1);
    check_eq("tl_conflict0", {39'b0, memwb[63:32]}, {39'b0, 32'h0000_0100});
    lw(32'h4000_0004, 1'b1);
    check_eq("tl_conflict1", {39'b0, memwb[63:32]}, {39'b0, 32'h0000_0101});
    sw(32'h4000_0008, 32'h0000_0000);
    repeat (2) lw(32'h4000_0004, 1'b1);
`else
    sw(32'h4000_0008, 32'h0000_0007);
    lw(32'h4000_0008, 1'b1);
    check_eq("tcon_absent", {39'b0, memwb[63:32]}, 71'h0);
`endif

    for (int i = 0; i < 500; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = rand_addr();
      d = $urandom;
      if (a[31:2] == 30'h1000_0001 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      switch = 8'($urandom);
      step(5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), d, a);
    end

    // Reset mid-write: LED store and RAM store both squashed
    exmem = {5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0055, 32'h4000_000C};
    #2;
    reset = 1'b1;
    #1;
    check_eq("rstw_led",    {63'b0, led}, 71'h0);
    check_eq("rstw_memwb",  memwb, 71'h0);
    check_eq("rstw_irqout", {70'b0, irqout}, 71'h0);
    exmem = {5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0010};
    @(posedge clk);
    #1;
    check_eq("rstw_led2", {63'b0, led}, 71'h0);
    check_eq("rstw_digi", {59'b0, digi}, 71'h0);
    reset   = 1'b0;
    m_led   = '0;
    m_digi  = '0;
    m_th    = '0;
    m_tl    = '0;
    m_tcon  = '0;
    lw(32'h10, 1'b1);
    check_eq("ram_retained", {39'b0, wb_data}, {39'b0, m_ram[4]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
